// File: rtl/pfx_if.sv
// Partition fixpoint engine bus: run request, target/limit and results.
// Master drives the request side; the engine takes the slave side.
interface pfx_if #(
  parameter int W   = 3,
  parameter int NCH = 3,
  parameter int SW  = 8
);
  localparam int S  = 2*W+2;
  localparam int HW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             start;
  logic [NCH*S-1:0] init_state;
  logic [S-1:0]     tgt_state;
  logic [SW-1:0]    max_steps;
  logic             busy;
  logic             done;
  logic             hit;
  logic [HW-1:0]    hit_idx;
  logic             cycled;
  logic             timeout;
  logic [SW-1:0]    steps;
  logic [NCH*S-1:0] state_q;

  modport master (
    output start, init_state, tgt_state, max_steps,
    input  busy, done, hit, hit_idx, cycled,
    input  timeout, steps, state_q
  );

  modport slave (
    input  start, init_state, tgt_state, max_steps,
    output busy, done, hit, hit_idx, cycled,
    output timeout, steps, state_q
  );
endinterface

// File: rtl/partition_fixpoint_engine.sv
// Steps NCH {m,b,a} channels until target hit, return to start or step limit.
// Build option PFX_BIDIR_EN makes b count down in mode 2'b10.
module partition_fixpoint_engine #(
  parameter int W   = 3,
  parameter int NCH = 3,
  parameter int SW  = 8
) (
  input  logic clk,
  input  logic rst_n,
  pfx_if.slave bus
);
  localparam int S  = 2*W+2;
  localparam int N  = NCH*S;
  localparam int HW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        st_q, st_d;
  logic [N-1:0]  cur_q, cur_d;
  logic [N-1:0]  snap_q, snap_d;
  logic [N-1:0]  stepped;
  logic [SW-1:0] steps_q, steps_d;
  logic          hit_q, hit_d;
  logic          cyc_q, cyc_d;
  logic          to_q, to_d;
  logic [HW-1:0] idx_q, idx_d;
  logic          any_hit;
  logic [HW-1:0] hit_sel;
  logic          is_cyc;
  logic          is_to;

  function automatic logic [S-1:0] step_ch(
    input logic [S-1:0] c
  );
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   m;
    a = c[W-1:0];
    b = c[2*W-1:W];
    m = c[S-1:2*W];
    if (!(m[1] ^ m[0])) begin
      a = a + 1'b1;
    end else begin
`ifdef PFX_BIDIR_EN
      if (m == 2'b10) b = b - 1'b1;
      else            b = b + 1'b1;
`else
      b = b + 1'b1;
`endif
    end
    m = {m[0], ~m[1]};
    return {m, b, a};
  endfunction

  always_comb begin
    stepped = '0;
    for (int i = 0; i < NCH; i++) begin
      stepped[i*S +: S] = step_ch(cur_q[i*S +: S]);
    end
  end

  // Scan high to low so the lowest matching channel wins.
  always_comb begin
    any_hit = 1'b0;
    hit_sel = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (cur_q[i*S +: S] == bus.tgt_state) begin
        any_hit = 1'b1;
        hit_sel = HW'(i);
      end
    end
  end

  assign is_cyc = (steps_q != '0) && (cur_q == snap_q);
  assign is_to  = (steps_q == bus.max_steps);

  always_comb begin
    st_d    = st_q;
    cur_d   = cur_q;
    snap_d  = snap_q;
    steps_d = steps_q;
    hit_d   = hit_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    idx_d   = idx_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = RUN;
          cur_d   = bus.init_state;
          snap_d  = bus.init_state;
          steps_d = '0;
          hit_d   = 1'b0;
          cyc_d   = 1'b0;
          to_d    = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (any_hit) begin
          st_d  = DONE;
          hit_d = 1'b1;
          idx_d = hit_sel;
        end else if (is_cyc) begin
          st_d  = DONE;
          cyc_d = 1'b1;
        end else if (is_to) begin
          st_d = DONE;
          to_d = 1'b1;
        end else begin
          cur_d   = stepped;
          steps_d = steps_q + 1'b1;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cur_q   <= '0;
      snap_q  <= '0;
      steps_q <= '0;
      hit_q   <= 1'b0;
      cyc_q   <= 1'b0;
      to_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      st_q    <= st_d;
      cur_q   <= cur_d;
      snap_q  <= snap_d;
      steps_q <= steps_d;
      hit_q   <= hit_d;
      cyc_q   <= cyc_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy    = (st_q == RUN);
  assign bus.done    = (st_q == DONE);
  assign bus.hit     = hit_q;
  assign bus.hit_idx = idx_q;
  assign bus.cycled  = cyc_q;
  assign bus.timeout = to_q;
  assign bus.steps   = steps_q;
  assign bus.state_q = cur_q;
endmodule

// File: tb/tb_partition_fixpoint_engine.sv
// Scoreboard bench for partition_fixpoint_engine, default parameters.
// Expected results are queued at start; a monitor checks them on done.
module tb_partition_fixpoint_engine;
  logic clk;
  logic rst_n;

  pfx_if #(.W(3), .NCH(3), .SW(8)) bus ();

  partition_fixpoint_engine #(.W(3), .NCH(3), .SW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        hit;
    logic [1:0]  idx;
    logic        cyc;
    logic        to;
    logic [7:0]  steps;
    logic [23:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit",     32'(bus.hit),     32'(e.hit));
        chk("hit_idx", 32'(bus.hit_idx), 32'(e.idx));
        chk("cycled",  32'(bus.cycled),  32'(e.cyc));
        chk("timeout", 32'(bus.timeout), 32'(e.to));
        chk("steps",   32'(bus.steps),   32'(e.steps));
        chk("state_q", 32'(bus.state_q), 32'(e.state));
      end
    end
  end

  function automatic exp_t mk(input logic h, input logic [1:0] ix,
                              input logic c, input logic t,
                              input logic [7:0] st,
                              input logic [23:0] sq);
    exp_t e;
    e.hit = h; e.idx = ix; e.cyc = c; e.to = t;
    e.steps = st; e.state = sq;
    return e;
  endfunction

  // poke: re-pulse start mid-run and scramble the init_state port.
  task automatic run(input logic [23:0] init, input logic [7:0] tgt,
                     input logic [7:0] mx, input exp_t e,
                     input bit poke, input int lat);
    int n;
    exp_q.push_back(e);
    @(negedge clk);
    bus.init_state = init;
    bus.tgt_state  = tgt;
    bus.max_steps  = mx;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      bus.init_state = ~init;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (lat >= 0) begin
      chk("done_latency", 32'(n), 32'(lat));
    end
    @(negedge clk);
    @(negedge clk);
    chk("hold_steps", 32'(bus.steps),   32'(e.steps));
    chk("hold_state", 32'(bus.state_q), 32'(e.state));
    chk("idle_busy",  32'(bus.busy),    32'd0);
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.init_state = '0;
    bus.tgt_state  = '0;
    bus.max_steps  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_done",  32'(bus.done),    32'd0);
    chk("rst_steps", 32'(bus.steps),   32'd0);
    chk("rst_state", 32'(bus.state_q), 32'd0);
    rst_n = 1'b1;

    // ch0 hits {01,000,001} after one step
    run(24'hED_ED_00, 8'h41, 8'd20,
        mk(1, 2'd0, 0, 0, 8'd1, 24'hAE_AE_41), 0, -1);
    // unreachable target: full period of 16 steps
    run(24'h00_00_00, 8'h07, 8'd50,
        mk(0, 2'd0, 1, 0, 8'd16, 24'h00_00_00), 1, -1);
    // step limit 0
    run(24'h00_00_00, 8'h07, 8'd0,
        mk(0, 2'd0, 0, 1, 8'd0, 24'h00_00_00), 0, 1);
    // ch2 equals target at step 0
    run(24'h5A_00_00, 8'h5A, 8'd0,
        mk(1, 2'd2, 0, 0, 8'd0, 24'h5A_00_00), 0, 1);
    // step limit 5
    run(24'h00_00_00, 8'h07, 8'd5,
        mk(0, 2'd0, 0, 1, 8'd5, 24'h53_53_53), 0, -1);
    // ch1 and ch2 hit together at step 3, start re-pulsed in RUN
    run(24'h00_00_08, 8'h8A, 8'd40,
        mk(1, 2'd1, 0, 0, 8'd3, 24'h8A_8A_92), 1, -1);

    // reset mid-run at steps=5
    @(negedge clk);
    bus.init_state = 24'h0;
    bus.tgt_state  = 8'h07;
    bus.max_steps  = 8'd50;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.steps != 8'd5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_step5", 32'(bus.steps), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy),    32'd0);
    chk("arst_done",  32'(bus.done),    32'd0);
    chk("arst_steps", 32'(bus.steps),   32'd0);
    chk("arst_state", 32'(bus.state_q), 32'd0);
    chk("arst_flags",
        32'({bus.hit, bus.cycled, bus.timeout, bus.hit_idx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(24'h00_00_00, 8'h07, 8'd5,
        mk(0, 2'd0, 0, 1, 8'd5, 24'h53_53_53), 0, -1);

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/partition_fixpoint_engine.md
PARTITION_FIXPOINT_ENGINE -- requirements
Module: partition_fixpoint_engine

Interface
REQ-001 Parameter W, default 3: per-channel counter width in bits (W >= 2).
REQ-002 Parameter NCH, default 3: number of partition channels (NCH >= 1).
REQ-003 Parameter SW, default 8: width of the step counter and step limit.
REQ-004 Derived S = 2W+2: channel state width; packing, MSB to LSB, is {m[1:0], b[W-1:0], a[W-1:0]}; channel i occupies bits [i*S +: S].
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  request a run; sampled only in IDLE.
REQ-008 init_state  in  NCH*S  initial state of all channels; sampled when start is accepted.
REQ-009 tgt_state  in  S  target state; held stable by the user for the whole run.
REQ-010 max_steps  in  SW  step limit; held stable by the user for the whole run.
REQ-011 busy  out  1  high in RUN.
REQ-012 done  out  1  one-cycle pulse in DONE.
REQ-013 hit  out  1  run ended on a target match.
REQ-014 hit_idx  out  clog2(NCH) (min 1)  lowest matching channel index.
REQ-015 cycled  out  1  run ended because the state returned to init_state.
REQ-016 timeout  out  1  run ended on the step limit.
REQ-017 steps  out  SW  number of transitions taken.
REQ-018 state_q  out  NCH*S  current channel state.

Function
REQ-019 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start=1: load state_q<=init_state, steps<=0, clear hit/cycled/timeout/hit_idx.
- RUN->DONE on termination.
- DONE->IDLE unconditionally after one cycle.
REQ-020 The per-channel transition is applied in RUN when no termination holds:
- dir = m[1]^m[0].
- dir=0: a<=a+1 mod 2^W.
- dir=1: b<=b+1 mod 2^W.
- m<={m[0], ~m[1]}, giving the sequence 00->01->11->10->00.
REQ-021 Channels are independent; all NCH channels step in the same cycle.
REQ-022 Termination is evaluated each RUN cycle on the registered state_q, with priority hit > cycled > timeout:
- hit: any channel equals tgt_state.
- cycled: steps!=0 and state_q==init_state snapshot (the full vector).
- timeout: steps==max_steps.
REQ-023 On termination, the cause flag is set, no transition occurs, and steps and state_q freeze.
REQ-024 hit_idx = lowest matching channel index; it is 0 when hit=0.
REQ-025 init_state is captured into an internal snapshot at start; later changes on the init_state port do not affect the cycled check.
REQ-026 A match at step 0 terminates with hit=1 and steps=0.
REQ-027 max_steps=0 with no step-0 hit terminates with timeout=1 and steps=0.
REQ-028 steps increments by 1 per transition; it cannot wrap, because timeout at max_steps <= 2^SW-1 precedes any wrap.
REQ-029 start is ignored in RUN and DONE.
REQ-030 Result outputs (hit, hit_idx, cycled, timeout, steps, state_q) hold from DONE until the next accepted start.

Reset
REQ-031 rst_n=0, including mid-run, immediately forces IDLE and zeroes every output and internal register, including the snapshot.
REQ-032 Operation resumes on the first rising clk edge after rst_n deasserts; no start is lost or replayed.

Configuration
REQ-033 Macro PFX_BIDIR_EN selects the b update for dir=1.
- Defined: when m==2'b10, b<=b-1 mod 2^W; when m==2'b01, b<=b+1.
- Undefined: b<=b+1 for both dir=1 modes.
- All other behaviour is identical in both builds.

Verification
REQ-034 Defaults, no macro; ch0 a=0,b=0,m=00, ch1 and ch2 a=5,b=5,m=11; tgt {m=01,b=0,a=1}; max_steps=20; pulse start -> done with hit=1, hit_idx=0, steps=1.
REQ-035 Defaults, no macro; all channels a=0,b=0,m=00; tgt unreachable (m=00, a=7, b=0); max_steps=50 -> cycled=1, steps=16, state_q==init_state.
REQ-036 PFX_BIDIR_EN defined; same stimulus as REQ-035 -> cycled=1, steps=16; at step 4, b=0 and a=2 on every channel.
REQ-037 max_steps=0, no channel matching tgt -> done two cycles after start, timeout=1, steps=0; with ch2==tgt instead -> hit=1, hit_idx=2, steps=0.
REQ-038 Assert rst_n=0 at steps=5 in RUN -> busy=0 and all outputs 0 asynchronously; a new start after release gives results identical to a fresh run.
REQ-039 ch1 and ch2 both reach tgt at the same step -> hit_idx=1; start pulsed during RUN -> no effect on steps or results.
